// File: rtl/id_scoreboard_ctrl.sv
// Decode-stage register scoreboard: per-GPR pending-writer counters gate id_readygo.
// Define SCB_PERF_EN to build the stall_cycles performance counter.
module id_scoreboard_ctrl #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic          id_rs1_used,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_rs2_used,
  input  logic          id_gr_we,
  input  logic [AW-1:0] id_dest,
  input  logic          ex_allowin,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_dest,
  input  logic          flush,
  output logic          id_readygo,
  output logic          pend_any,
  output logic          scb_err,
  output logic [31:0]   stall_cycles
);

  logic [CNT_W-1:0] cnt [1:NREG-1];
  logic             pend_rs1;
  logic             pend_rs2;
  logic             hazard;
  logic             issue;
  logic             retire;

  // r0 has no counter, so a source of r0 never matches any loop index.
  always_comb begin
    pend_rs1 = 1'b0;
    pend_rs2 = 1'b0;
    pend_any = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (cnt[r] != '0) begin
        pend_any = 1'b1;
        if (id_rs1 == AW'(r)) pend_rs1 = 1'b1;
        if (id_rs2 == AW'(r)) pend_rs2 = 1'b1;
      end
    end
  end

  assign hazard     = id_valid & ((id_rs1_used & pend_rs1) | (id_rs2_used & pend_rs2));
  assign id_readygo = ~hazard;
  assign issue      = id_valid & id_readygo & ex_allowin & id_gr_we & (id_dest != '0);
  assign retire     = wb_we & (wb_dest != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 1; r < NREG; r++) cnt[r] <= '0;
      scb_err <= 1'b0;
    end else if (flush) begin
      for (int unsigned r = 1; r < NREG; r++) cnt[r] <= '0;
    end else begin
      // Issue and retire hitting the same register cancel out.
      for (int unsigned r = 1; r < NREG; r++) begin
        if (issue && id_dest == AW'(r) && !(retire && wb_dest == AW'(r))) begin
          if (cnt[r] == '1) scb_err <= 1'b1;
          else              cnt[r]  <= cnt[r] + CNT_W'(1);
        end else if (retire && wb_dest == AW'(r) && !(issue && id_dest == AW'(r))) begin
          if (cnt[r] == '0) scb_err <= 1'b1;
          else              cnt[r]  <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

`ifdef SCB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       stall_cycles <= '0;
    else if (id_valid && hazard)    stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Bench for id_scoreboard_ctrl: directed hazard scenarios then random traffic,
// checked each cycle against a per-register pending-count model.
module tb_id_scoreboard_ctrl;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs1_used, id_rs2_used, id_gr_we, ex_allowin, wb_we, flush;
  logic [AW-1:0] id_rs1, id_rs2, id_dest, wb_dest;
  logic          id_readygo, pend_any, scb_err;
  logic [31:0]   stall_cycles;

  int          checks   = 0;
  int          failures = 0;
  int          mcnt [NREG];
  bit          merr;
  logic [31:0] mstall;

  always #5 clk = ~clk;

  id_scoreboard_ctrl #(.NREG(NREG), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_gr_we(id_gr_we),
    .id_dest(id_dest), .ex_allowin(ex_allowin), .wb_we(wb_we),
    .wb_dest(wb_dest), .flush(flush), .id_readygo(id_readygo),
    .pend_any(pend_any), .scb_err(scb_err), .stall_cycles(stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit mpend(input logic [AW-1:0] r);
    return (r != 0) && (mcnt[r] != 0);
  endfunction

  function automatic bit mready();
    return !(id_valid && ((id_rs1_used && mpend(id_rs1)) || (id_rs2_used && mpend(id_rs2))));
  endfunction

  function automatic bit many();
    for (int r = 1; r < NREG; r++) if (mcnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    merr   = 1'b0;
    mstall = '0;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_stall;
`ifdef SCB_PERF_EN
    exp_stall = mstall;
`else
    exp_stall = '0;
`endif
    check_eq({tag, "/readygo"}, {31'd0, id_readygo}, {31'd0, mready()});
    check_eq({tag, "/pend_any"}, {31'd0, pend_any}, {31'd0, many()});
    check_eq({tag, "/scb_err"}, {31'd0, scb_err}, {31'd0, merr});
    check_eq({tag, "/stall"}, stall_cycles, exp_stall);
  endtask

  // Applies the scoreboard rules to the model for the edge about to happen.
  task automatic model_edge();
    bit rdy, iss, ret;
    rdy = mready();
    if (id_valid && !rdy) mstall = mstall + 32'd1;
    if (flush) begin
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    end else begin
      iss = id_valid && rdy && ex_allowin && id_gr_we && (id_dest != 0);
      ret = wb_we && (wb_dest != 0);
      if (!(iss && ret && id_dest == wb_dest)) begin
        if (iss) begin
          if (mcnt[id_dest] == CMAX) merr = 1'b1;
          else mcnt[id_dest]++;
        end
        if (ret) begin
          if (mcnt[wb_dest] == 0) merr = 1'b1;
          else mcnt[wb_dest]--;
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    #1;
    check_outputs(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = '0; id_rs1_used = 0; id_rs2 = '0; id_rs2_used = 0;
    id_gr_we = 0; id_dest = '0; ex_allowin = 1; wb_we = 0; wb_dest = '0; flush = 0;
  endtask

  task automatic issue_to(input logic [AW-1:0] d);
    idle();
    id_valid = 1; id_gr_we = 1; id_dest = d;
  endtask

  task automatic probe(input logic [AW-1:0] r);
    idle();
    id_valid = 1; id_rs1 = r; id_rs1_used = 1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = AW'($urandom_range(0, 15));
      id_rs1_used = $urandom_range(0, 1) != 0;
      id_rs2      = AW'($urandom_range(0, 15));
      id_rs2_used = $urandom_range(0, 1) != 0;
      id_gr_we    = $urandom_range(0, 1) != 0;
      id_dest     = AW'($urandom_range(0, 15));
      ex_allowin  = ($urandom_range(0, 3) != 0);
      wb_we       = $urandom_range(0, 1) != 0;
      wb_dest     = AW'($urandom_range(0, 15));
      flush       = ($urandom_range(0, 63) == 0);
      tick("rand");
    end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    check_eq("reset_readygo", {31'd0, id_readygo}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick("idle");

    // Load-use on r5: three stalls, then the retire cycle still stalls.
    issue_to(5);        tick("lu_issue");
    probe(5);           tick("lu_stall1");
    check_eq("lu_hold", {31'd0, id_readygo}, 32'd0);
    tick("lu_stall2");  tick("lu_stall3");
    wb_we = 1; wb_dest = 5;
    #1 check_eq("lu_wb_hold", {31'd0, id_readygo}, 32'd0);
    tick("lu_wb");
    wb_we = 0;
    #1 check_eq("lu_go", {31'd0, id_readygo}, 32'd1);
`ifdef SCB_PERF_EN
    check_eq("lu_stalls", stall_cycles, 32'd4);
`else
    check_eq("lu_stalls", stall_cycles, 32'd0);
`endif
    tick("lu_after");

    // r0 never tracked; unused pending source ignored.
    issue_to(0);        tick("r0_issue");
    probe(0);           tick("r0_read");
    issue_to(7);        tick("r7_issue");
    idle(); id_valid = 1; id_rs2 = 7; id_rs2_used = 0;
    #1 check_eq("r7_unused", {31'd0, id_readygo}, 32'd1);
    tick("r7_unused");
    idle(); wb_we = 1; wb_dest = 7; tick("r7_retire");

    // Same-cycle issue and retire of r9 keeps the count at 1.
    issue_to(9);        tick("r9_issue");
    issue_to(9); wb_we = 1; wb_dest = 9; tick("r9_both");
    probe(9);           tick("r9_probe");
    idle(); wb_we = 1; wb_dest = 9; tick("r9_retire");
    probe(9);
    #1 check_eq("r9_clear", {31'd0, id_readygo}, 32'd1);
    tick("r9_clear");

    // Overflow on r3.
    for (int k = 0; k < 4; k++) begin
      issue_to(3); tick("r3_issue");
    end
    idle();
    #1 check_eq("r3_overflow", {31'd0, scb_err}, 32'd1);
    tick("r3_after");

    // Asynchronous reset mid-cycle with r5 pending.
    issue_to(5);        tick("rst_issue");
    probe(5);
    #1 check_outputs("rst_pre");
    #2 rst = 1'b0;
    model_reset();
    #1 check_outputs("rst_mid");
    check_eq("rst_pend_any", {31'd0, pend_any}, 32'd0);
    check_eq("rst_err", {31'd0, scb_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick("rst_after");

    // Flush beats a concurrent issue.
    issue_to(4); tick("fl_a"); tick("fl_b");
    issue_to(8); tick("fl_c");
    issue_to(10); flush = 1; tick("fl_flush");
    idle();
    #1 check_eq("fl_pend_any", {31'd0, pend_any}, 32'd0);
    tick("fl_after");
    probe(10); tick("fl_r10");

    // Underflow on r12, sticky through flush.
    idle(); wb_we = 1; wb_dest = 12; tick("uf_retire");
    idle(); tick("uf_err");
    flush = 1; tick("uf_flush");
    flush = 0;
    #1 check_eq("uf_sticky", {31'd0, scb_err}, 32'd1);
    probe(12); tick("uf_probe");

    random_run(2000);
    idle();
    do_reset();
    tick("rand_reset");
    random_run(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_scoreboard_ctrl.md
Name: id_scoreboard_ctrl

Overview:
- Register-hazard scheduler for the decode stage.
- Tracks in-flight register writers between ID issue and WB regfile write, using per-register pending counters.
- Produces the ID `readygo` that throttles the ID→EX handshake, replacing the constant `readygo=1`.
- Sits beside the decode stage: fed by decode fields, the ID→EX handshake and the WB regfile write bus.

Parameters:
- NREG, 32: number of architectural GPRs; r0 is never tracked.
- AW, 5: register address width; log2(NREG).
- CNT_W, 2: width of each pending counter; max in-flight writers per register is 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1  in  AW  first source register (rj).
- id_rs1_used  in  1  rs1 is actually read by this instruction.
- id_rs2  in  AW  second source register (rk, or rd for store/branch).
- id_rs2_used  in  1  rs2 is actually read.
- id_gr_we  in  1  instruction writes the GPR file.
- id_dest  in  AW  destination register.
- ex_allowin  in  1  EX accepts a new instruction this cycle.
- wb_we  in  1  WB writes the regfile this cycle (rf_we, already valid-qualified).
- wb_dest  in  AW  WB write address.
- flush  in  1  discard all in-flight tracking; pipeline is being emptied.
- id_readygo  out  1  ID may hand off this cycle.
- pend_any  out  1  at least one counter is non-zero.
- scb_err  out  1  sticky error: counter overflow or underflow.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- State: cnt[1..NREG-1], each CNT_W bits. No cnt[0] exists; reads of r0 are never pending.
- pending(r) = (r!=0) && (cnt[r]!=0), computed from registered state only.
- hazard = id_valid & ((id_rs1_used & pending(id_rs1)) | (id_rs2_used & pending(id_rs2))).
- id_readygo = ~hazard. It is combinational, with zero cycles of latency from the inputs.
- A WB write in the same cycle does not clear a hazard. The regfile writes at the clock edge, so ID sees correct data the following cycle; that is one stall cycle on retire.
- issue = id_valid & id_readygo & ex_allowin & id_gr_we & (id_dest!=0).
- retire = wb_we & (wb_dest!=0).
- Per-register update at the clock edge, with priority in this order:
  1. reset: cnt=0.
  2. flush: cnt=0.
  3. issue and retire to the same register: unchanged.
  4. issue only: +1. If the counter is already at max it holds and scb_err is set.
  5. retire only: -1. If the counter is already 0 it holds at 0 and scb_err is set.
- issue and retire to different registers in the same cycle are independent updates.
- flush together with issue: flush wins and the issued instruction is not tracked.
- Reset values:
  - all counters 0.
  - id_readygo = ~id_valid-hazard, which is 1 because nothing is pending.
  - pend_any=0, scb_err=0, stall_cycles=0.
- Asynchronous assert takes effect immediately. Reset mid-operation discards all pending state.
- scb_err clears only on reset. flush does not clear it.
- Combinational path from ex_allowin to id_readygo: none. id_readygo must not depend on ex_allowin.

Optional Feature:
- Macro: SCB_PERF_EN.
- Defined:
  - stall_cycles increments every cycle with id_valid & ~id_readygo.
  - Wraps modulo 2^32.
  - Cleared by reset only.
- Undefined:
  - No counter logic is built.
  - stall_cycles is tied to 32'h0.
  - The port is present in both cases.

Test Plan:
- Reset: hold rst=0 mid-run with cnt[5]=1, then release. Required: pend_any=0, id_readygo=1, scb_err=0, stall_cycles=0.
- Load-use: issue dest=5; next cycle ID has id_rs1=5, id_rs1_used=1. Required: id_readygo=0 until the cycle after wb_we=1, wb_dest=5; then id_readygo=1. With SCB_PERF_EN, stall_cycles equals the number of stalled cycles, e.g. 4.
- r0 and unused sources: issue dest=0, then rs1=0 used; also rs2=7 pending with id_rs2_used=0. Required: id_readygo stays 1 and cnt is unchanged.
- Same-cycle issue and retire of r9 with cnt[9]=1: required cnt[9]=1 after the edge. Three issues to r3 with no retire gives cnt=3; a fourth issue gives cnt=3 and scb_err=1.
- Flush: cnt[4]=2 and cnt[8]=1, assert flush together with an issue to r10. Required: all counters 0, pend_any=0, r10 not pending.
- Underflow: wb_we=1, wb_dest=12 with cnt[12]=0. Required: cnt[12] stays 0 and scb_err=1, sticky through a later flush.
